// File: rtl/layer_sequencer.sv
// layer_sequencer: issues forward then backward layer numbers for each sample
// and counts samples within an epoch.
module layer_sequencer #(
    parameter int unsigned LAYER_ADDR_WIDTH = 2,
    parameter int unsigned SAMPLE_WIDTH     = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic                        train,
    input  logic [LAYER_ADDR_WIDTH-1:0] layer_top,
    input  logic [SAMPLE_WIDTH-1:0]     samples_total,
    output logic [LAYER_ADDR_WIDTH-1:0] fw_layer,
    output logic                        fw_layer_valid,
    input  logic                        fw_layer_ready,
    output logic [LAYER_ADDR_WIDTH-1:0] bw_layer,
    output logic                        bw_layer_valid,
    input  logic                        bw_layer_ready,
    input  logic                        fw_done,
    input  logic                        bw_done,
    output logic                        busy,
    output logic [SAMPLE_WIDTH-1:0]     sample_count,
    output logic                        epoch_done
);

    typedef enum logic [2:0] {
        IDLE,
        FW_ISSUE,
        FW_WAIT,
        BW_ISSUE,
        BW_WAIT,
        SAMPLE_END
    } state_t;

    state_t                      state, state_d;
    logic [LAYER_ADDR_WIDTH-1:0] top_r, top_d;
    logic [SAMPLE_WIDTH-1:0]     total_r, total_d;
    logic [LAYER_ADDR_WIDTH-1:0] fw_layer_d, bw_layer_d;
    logic                        fw_valid_d, bw_valid_d;
    logic                        fw_flag, fw_flag_d;
    logic                        bw_flag, bw_flag_d;
    logic [SAMPLE_WIDTH-1:0]     count_d;
    logic                        epoch_d;
    logic                        busy_d;
    logic                        start_sample;
    logic                        fw_xfer, bw_xfer;
    logic                        last_sample;

    assign fw_xfer     = fw_layer_valid && fw_layer_ready;
    assign bw_xfer     = bw_layer_valid && bw_layer_ready;
    // A zero total is treated as a one-sample epoch so the counter never runs away.
    assign last_sample = (total_r == '0) || (sample_count == total_r - SAMPLE_WIDTH'(1));

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            top_r          <= '0;
            total_r        <= '0;
            fw_layer       <= '0;
            fw_layer_valid <= 1'b0;
            bw_layer       <= '0;
            bw_layer_valid <= 1'b0;
            fw_flag        <= 1'b0;
            bw_flag        <= 1'b0;
            sample_count   <= '0;
            epoch_done     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_d;
            top_r          <= top_d;
            total_r        <= total_d;
            fw_layer       <= fw_layer_d;
            fw_layer_valid <= fw_valid_d;
            bw_layer       <= bw_layer_d;
            bw_layer_valid <= bw_valid_d;
            fw_flag        <= fw_flag_d;
            bw_flag        <= bw_flag_d;
            sample_count   <= count_d;
            epoch_done     <= epoch_d;
            busy           <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        top_d        = top_r;
        total_d      = total_r;
        fw_layer_d   = fw_layer;
        fw_valid_d   = fw_layer_valid;
        bw_layer_d   = bw_layer;
        bw_valid_d   = bw_layer_valid;
        fw_flag_d    = fw_flag;
        bw_flag_d    = bw_flag;
        count_d      = sample_count;
        epoch_d      = 1'b0;
        busy_d       = 1'b0;
        start_sample = 1'b0;

        // Done pulses arriving before their wait state are remembered
        if (fw_done && (state != FW_WAIT)) fw_flag_d = 1'b1;
        if (bw_done && (state != BW_WAIT)) bw_flag_d = 1'b1;

        case (state)
            IDLE: begin
                start_sample = run;
            end
            FW_ISSUE: begin
                if (fw_xfer) begin
                    if (fw_layer == top_r) begin
                        fw_valid_d = 1'b0;
                        state_d    = FW_WAIT;
                    end else begin
                        fw_layer_d = fw_layer + LAYER_ADDR_WIDTH'(1);
                    end
                end
            end
            FW_WAIT: begin
                if (fw_done || fw_flag) begin
                    fw_flag_d = 1'b0;
                    if (train && (top_r != '0)) begin
                        bw_layer_d = top_r - LAYER_ADDR_WIDTH'(1);
                        bw_valid_d = 1'b1;
                        state_d    = BW_ISSUE;
                    end else begin
                        epoch_d = last_sample;
                        state_d = SAMPLE_END;
                    end
                end
            end
            BW_ISSUE: begin
                if (bw_xfer) begin
                    if (bw_layer == '0) begin
                        bw_valid_d = 1'b0;
                        state_d    = BW_WAIT;
                    end else begin
                        bw_layer_d = bw_layer - LAYER_ADDR_WIDTH'(1);
                    end
                end
            end
            BW_WAIT: begin
                if (bw_done || bw_flag) begin
                    bw_flag_d = 1'b0;
                    epoch_d   = last_sample;
                    state_d   = SAMPLE_END;
                end
            end
            SAMPLE_END: begin
                fw_flag_d = 1'b0;
                bw_flag_d = 1'b0;
                count_d   = last_sample ? '0 : sample_count + SAMPLE_WIDTH'(1);
                if (run) begin
                    start_sample = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Sample start: latch the per-sample parameters and present layer 0
        if (start_sample) begin
            top_d      = layer_top;
            total_d    = samples_total;
            fw_layer_d = '0;
            fw_valid_d = 1'b1;
            state_d    = FW_ISSUE;
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: randomized scenarios checked against a sequence-level model
module tb_layer_sequencer;

    localparam int unsigned LAW = 2;
    localparam int unsigned SW  = 10;

    logic           clk;
    logic           rst;
    logic           run;
    logic           train;
    logic [LAW-1:0] layer_top;
    logic [SW-1:0]  samples_total;
    logic [LAW-1:0] fw_layer;
    logic           fw_layer_valid;
    logic           fw_layer_ready;
    logic [LAW-1:0] bw_layer;
    logic           bw_layer_valid;
    logic           bw_layer_ready;
    logic           fw_done;
    logic           bw_done;
    logic           busy;
    logic [SW-1:0]  sample_count;
    logic           epoch_done;

    int n_checks;
    int n_errors;

    // Environment state
    int             cyc;
    int             ready_mode;
    int             fw_delay;
    int             bw_delay;
    int             env_top;
    bit             fw_early;
    bit             early_sent;
    bit             bw_forbidden;
    int             fw_cd;
    int             bw_cd;
    bit             pend_fw;
    bit             pend_bw;
    logic [LAW-1:0] held_fw;
    logic [LAW-1:0] held_bw;
    logic           prev_bw_valid;
    string          fw_log;
    string          bw_log;
    int             fw_zero_cnt;
    int             fw_first_cyc;
    int             fw_last_cyc;
    int             bw_gap;
    int             epoch_cnt;

    layer_sequencer #(
        .LAYER_ADDR_WIDTH(LAW),
        .SAMPLE_WIDTH    (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .train         (train),
        .layer_top     (layer_top),
        .samples_total (samples_total),
        .fw_layer      (fw_layer),
        .fw_layer_valid(fw_layer_valid),
        .fw_layer_ready(fw_layer_ready),
        .bw_layer      (bw_layer),
        .bw_layer_valid(bw_layer_valid),
        .bw_layer_ready(bw_layer_ready),
        .fw_done       (fw_done),
        .bw_done       (bw_done),
        .busy          (busy),
        .sample_count  (sample_count),
        .epoch_done    (epoch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit
    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, required finish before 900000 ns");
        $fatal(1, "watchdog expired");
    end

    // Consumer-side environment: readies, done pulses, transfer log, handshake rules
    always @(negedge clk) begin
        cyc++;
        fw_done = 1'b0;
        bw_done = 1'b0;
        if (!rst) begin
            fw_cd         = 0;
            bw_cd         = 0;
            pend_fw       = 1'b0;
            pend_bw       = 1'b0;
            prev_bw_valid = 1'b0;
        end else begin
            if (fw_cd > 0) begin
                fw_cd--;
                if (fw_cd == 0) fw_done = 1'b1;
            end
            if (bw_cd > 0) begin
                bw_cd--;
                if (bw_cd == 0) bw_done = 1'b1;
            end
            case (ready_mode)
                0: begin fw_layer_ready = 1'b1; bw_layer_ready = 1'b1; end
                1: begin fw_layer_ready = ~fw_layer_ready; bw_layer_ready = ~bw_layer_ready; end
                2: begin
                    fw_layer_ready = 1'($urandom_range(0, 1));
                    bw_layer_ready = 1'($urandom_range(0, 1));
                end
                default: begin fw_layer_ready = 1'b0; bw_layer_ready = 1'b0; end
            endcase
            if (pend_fw) begin
                n_checks++;
                if (fw_layer_valid !== 1'b1 || fw_layer !== held_fw) begin
                    n_errors++;
                    $display("FAIL fw_hold: got valid=%b layer=%0d, required valid=1 layer=%0d",
                             fw_layer_valid, fw_layer, held_fw);
                end
            end
            if (pend_bw) begin
                n_checks++;
                if (bw_layer_valid !== 1'b1 || bw_layer !== held_bw) begin
                    n_errors++;
                    $display("FAIL bw_hold: got valid=%b layer=%0d, required valid=1 layer=%0d",
                             bw_layer_valid, bw_layer, held_bw);
                end
            end
            if (bw_forbidden) begin
                n_checks++;
                if (bw_layer_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL bw_forbidden: got bw_layer_valid=%b, required 0", bw_layer_valid);
                end
            end
            if (fw_early && !early_sent && fw_layer_valid === 1'b1 && fw_layer == '0) begin
                fw_done    = 1'b1;
                early_sent = 1'b1;
            end
            if (fw_layer_valid === 1'b1 && fw_layer_ready) begin
                fw_log = {fw_log, $sformatf("%0d,", fw_layer)};
                if (fw_layer == '0) begin
                    fw_zero_cnt++;
                    fw_first_cyc = cyc;
                end
                if (int'(fw_layer) == env_top) begin
                    fw_last_cyc = cyc;
                    if (fw_delay == 0) fw_done = 1'b1;
                    else if (fw_delay > 0) fw_cd = fw_delay;
                end
            end
            pend_fw = (fw_layer_valid === 1'b1) && !fw_layer_ready;
            held_fw = fw_layer;
            if (bw_layer_valid === 1'b1 && prev_bw_valid !== 1'b1)
                bw_gap = cyc - fw_last_cyc - 1;
            if (bw_layer_valid === 1'b1 && bw_layer_ready) begin
                bw_log = {bw_log, $sformatf("%0d,", bw_layer)};
                if (bw_layer == '0) begin
                    if (bw_delay == 0) bw_done = 1'b1;
                    else bw_cd = bw_delay;
                end
            end
            pend_bw       = (bw_layer_valid === 1'b1) && !bw_layer_ready;
            held_bw       = bw_layer;
            prev_bw_valid = bw_layer_valid;
            if (epoch_done === 1'b1) epoch_cnt++;
        end
    end

    // Reference model: layer sequences and epoch arithmetic per run of n samples
    function automatic string exp_fw(input int n, input int top);
        string s = "";
        for (int i = 0; i < n; i++)
            for (int l = 0; l <= top; l++) s = {s, $sformatf("%0d,", l)};
        return s;
    endfunction

    function automatic string exp_bw(input int n, input int top, input bit trn);
        string s = "";
        if (trn && top > 0)
            for (int i = 0; i < n; i++)
                for (int l = top - 1; l >= 0; l--) s = {s, $sformatf("%0d,", l)};
        return s;
    endfunction

    function automatic int exp_count(input int start, input int n, input int total);
        return (total == 0) ? 0 : (start + n) % total;
    endfunction

    function automatic int exp_epochs(input int start, input int n, input int total);
        return (total == 0) ? n : (start + n) / total;
    endfunction

    function automatic int exp_gap(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_env();
        fw_log       = "";
        bw_log       = "";
        fw_zero_cnt  = 0;
        fw_first_cyc = 0;
        fw_last_cyc  = 0;
        bw_gap       = -1;
        epoch_cnt    = 0;
    endtask

    task automatic reset_dut();
        run          = 1'b0;
        rst          = 1'b0;
        ready_mode   = 0;
        fw_early     = 1'b0;
        early_sent   = 1'b0;
        fw_delay     = 2;
        bw_delay     = 2;
        bw_forbidden = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        clear_env();
    endtask

    // Run n samples back to back, dropping run partway through the last one
    task automatic drive_samples(input int n, input int top, input int total, input bit trn);
        int start;
        int budget;
        layer_top     = LAW'(top);
        samples_total = SW'(total);
        train         = trn;
        env_top       = top;
        bw_forbidden  = !(trn && top > 0);
        start         = fw_zero_cnt;
        budget        = 0;
        run           = 1'b1;
        while (fw_zero_cnt < start + n && budget < 1000) begin
            tick();
            budget++;
        end
        run = 1'b0;
        while (busy === 1'b1 && budget < 1000) begin
            tick();
            budget++;
        end
        n_checks++;
        if (budget >= 1000) begin
            n_errors++;
            $display("FAIL drive_timeout: got %0d cycles, required under 1000", budget);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle_busy: got %b, required 0", busy);
        end
        layer_top  = 2'd3;
        train      = 1'b1;
        env_top    = 3;
        ready_mode = 3;
        run        = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (fw_layer_valid !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_pre_active: got valid=%b busy=%b, required 1 1", fw_layer_valid, busy);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (fw_layer_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_fw_valid: got %b, required 0", fw_layer_valid);
        end
        n_checks++;
        if (bw_layer_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_bw_valid: got %b, required 0", bw_layer_valid);
        end
        n_checks++;
        if (fw_layer !== '0 || bw_layer !== '0) begin
            n_errors++;
            $display("FAIL reset_layers: got fw=%0d bw=%0d, required 0 0", fw_layer, bw_layer);
        end
        n_checks++;
        if (busy !== 1'b0 || epoch_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got busy=%b epoch_done=%b, required 0 0", busy, epoch_done);
        end
        n_checks++;
        if (sample_count !== '0) begin
            n_errors++;
            $display("FAIL reset_count: got %0d, required 0", sample_count);
        end
        repeat (2) tick();
        n_checks++;
        if (fw_layer_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_held: got valid=%b busy=%b, required 0 0", fw_layer_valid, busy);
        end
        run = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_basic();
        reset_dut();
        ready_mode = 0;
        fw_delay   = 3;
        bw_delay   = 3;
        drive_samples(1, 2, 4, 1'b1);
        n_checks++;
        if (fw_log != "0,1,2,") begin
            n_errors++;
            $display("FAIL basic_fw_seq: got \"%s\", required \"0,1,2,\"", fw_log);
        end
        n_checks++;
        if (bw_log != "1,0,") begin
            n_errors++;
            $display("FAIL basic_bw_seq: got \"%s\", required \"1,0,\"", bw_log);
        end
        n_checks++;
        if (fw_last_cyc - fw_first_cyc != 2) begin
            n_errors++;
            $display("FAIL basic_fw_b2b: got %0d cycles span, required 2", fw_last_cyc - fw_first_cyc);
        end
        n_checks++;
        if (bw_gap != 3) begin
            n_errors++;
            $display("FAIL basic_bw_gap: got %0d, required 3", bw_gap);
        end
        n_checks++;
        if (sample_count !== SW'(1) || epoch_cnt != 0) begin
            n_errors++;
            $display("FAIL basic_count: got count=%0d epochs=%0d, required 1 0", sample_count, epoch_cnt);
        end
    endtask

    task automatic test_ready_toggle();
        int top;
        reset_dut();
        top        = int'($urandom_range(1, 3));
        ready_mode = 1;
        fw_delay   = int'($urandom_range(1, 3));
        bw_delay   = int'($urandom_range(1, 3));
        drive_samples(2, top, 8, 1'b1);
        n_checks++;
        if (fw_log != exp_fw(2, top)) begin
            n_errors++;
            $display("FAIL toggle_fw_seq: got \"%s\", required \"%s\"", fw_log, exp_fw(2, top));
        end
        n_checks++;
        if (bw_log != exp_bw(2, top, 1'b1)) begin
            n_errors++;
            $display("FAIL toggle_bw_seq: got \"%s\", required \"%s\"", bw_log, exp_bw(2, top, 1'b1));
        end
        n_checks++;
        if (sample_count !== SW'(2)) begin
            n_errors++;
            $display("FAIL toggle_count: got %0d, required 2", sample_count);
        end
    endtask

    task automatic test_inference();
        int top;
        reset_dut();
        top        = int'($urandom_range(0, 3));
        ready_mode = 2;
        drive_samples(2, top, 3, 1'b0);
        n_checks++;
        if (epoch_cnt != 0 || sample_count !== SW'(2)) begin
            n_errors++;
            $display("FAIL infer_mid: got epochs=%0d count=%0d, required 0 2", epoch_cnt, sample_count);
        end
        drive_samples(1, top, 3, 1'b0);
        n_checks++;
        if (epoch_cnt != 1 || sample_count !== '0) begin
            n_errors++;
            $display("FAIL infer_wrap: got epochs=%0d count=%0d, required 1 0", epoch_cnt, sample_count);
        end
        n_checks++;
        if (bw_log != "" || fw_log != exp_fw(3, top)) begin
            n_errors++;
            $display("FAIL infer_seq: got fw=\"%s\" bw=\"%s\", required fw=\"%s\" bw=\"\"",
                     fw_log, bw_log, exp_fw(3, top));
        end
    endtask

    task automatic test_early_done();
        int top;
        reset_dut();
        top        = int'($urandom_range(1, 3));
        ready_mode = 0;
        fw_early   = 1'b1;
        early_sent = 1'b0;
        fw_delay   = -1;
        bw_delay   = 2;
        drive_samples(1, top, 4, 1'b1);
        fw_early = 1'b0;
        n_checks++;
        if (bw_gap != 1) begin
            n_errors++;
            $display("FAIL early_bw_gap: got %0d, required 1", bw_gap);
        end
        n_checks++;
        if (bw_log != exp_bw(1, top, 1'b1) || sample_count !== SW'(1)) begin
            n_errors++;
            $display("FAIL early_seq: got bw=\"%s\" count=%0d, required \"%s\" 1",
                     bw_log, sample_count, exp_bw(1, top, 1'b1));
        end
    endtask

    task automatic test_top_zero();
        reset_dut();
        ready_mode = 2;
        fw_delay   = 2;
        drive_samples(1, 0, 2, 1'b1);
        n_checks++;
        if (fw_log != "0," || bw_log != "") begin
            n_errors++;
            $display("FAIL top0_seq: got fw=\"%s\" bw=\"%s\", required fw=\"0,\" bw=\"\"", fw_log, bw_log);
        end
        n_checks++;
        if (sample_count !== SW'(1)) begin
            n_errors++;
            $display("FAIL top0_count: got %0d, required 1", sample_count);
        end
    endtask

    task automatic test_stop();
        int budget;
        reset_dut();
        ready_mode    = 1;
        fw_delay      = 1;
        bw_delay      = 2;
        layer_top     = 2'd3;
        samples_total = SW'(5);
        train         = 1'b1;
        env_top       = 3;
        bw_forbidden  = 1'b0;
        run           = 1'b1;
        budget        = 0;
        while (bw_layer_valid !== 1'b1 && budget < 200) begin
            tick();
            budget++;
        end
        run = 1'b0;
        while (busy === 1'b1 && budget < 400) begin
            tick();
            budget++;
        end
        n_checks++;
        if (budget >= 200) begin
            n_errors++;
            $display("FAIL stop_timeout: got %0d cycles, required under 200", budget);
        end
        n_checks++;
        if (fw_log != "0,1,2,3," || bw_log != "2,1,0,") begin
            n_errors++;
            $display("FAIL stop_seq: got fw=\"%s\" bw=\"%s\", required \"0,1,2,3,\" \"2,1,0,\"", fw_log, bw_log);
        end
        repeat (5) tick();
        n_checks++;
        if (busy !== 1'b0 || fw_log != "0,1,2,3," || sample_count !== SW'(1)) begin
            n_errors++;
            $display("FAIL stop_idle: got busy=%b fw=\"%s\" count=%0d, required 0 \"0,1,2,3,\" 1",
                     busy, fw_log, sample_count);
        end
        // Reset asserted while a forward layer is stalled
        ready_mode = 3;
        run        = 1'b1;
        budget     = 0;
        while (fw_layer_valid !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (fw_layer_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_reset_valid: got %b, required 0", fw_layer_valid);
        end
        run = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        clear_env();
        ready_mode = 0;
        repeat (5) tick();
        n_checks++;
        if (fw_log != "" || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_after_reset: got fw=\"%s\" busy=%b, required \"\" 0", fw_log, busy);
        end
        drive_samples(1, 1, 2, 1'b1);
        n_checks++;
        if (fw_log != "0,1," || bw_log != "0," || sample_count !== SW'(1)) begin
            n_errors++;
            $display("FAIL stop_restart: got fw=\"%s\" bw=\"%s\" count=%0d, required \"0,1,\" \"0,\" 1",
                     fw_log, bw_log, sample_count);
        end
    endtask

    task automatic test_random();
        int top;
        int total;
        int n;
        bit trn;
        for (int it = 0; it < 8; it++) begin
            reset_dut();
            top        = int'($urandom_range(0, 3));
            total      = int'($urandom_range(0, 4));
            n          = int'($urandom_range(1, 5));
            trn        = 1'($urandom_range(0, 1));
            ready_mode = int'($urandom_range(0, 2));
            fw_delay   = int'($urandom_range(0, 4));
            bw_delay   = int'($urandom_range(0, 4));
            drive_samples(n, top, total, trn);
            n_checks++;
            if (fw_log != exp_fw(n, top)) begin
                n_errors++;
                $display("FAIL rand%0d_fw_seq: got \"%s\", required \"%s\"", it, fw_log, exp_fw(n, top));
            end
            n_checks++;
            if (bw_log != exp_bw(n, top, trn)) begin
                n_errors++;
                $display("FAIL rand%0d_bw_seq: got \"%s\", required \"%s\"", it, bw_log, exp_bw(n, top, trn));
            end
            n_checks++;
            if (int'(sample_count) != exp_count(0, n, total)) begin
                n_errors++;
                $display("FAIL rand%0d_count: got %0d, required %0d", it, sample_count, exp_count(0, n, total));
            end
            n_checks++;
            if (epoch_cnt != exp_epochs(0, n, total)) begin
                n_errors++;
                $display("FAIL rand%0d_epochs: got %0d, required %0d", it, epoch_cnt, exp_epochs(0, n, total));
            end
            if (trn && top > 0) begin
                n_checks++;
                if (bw_gap != exp_gap(fw_delay)) begin
                    n_errors++;
                    $display("FAIL rand%0d_bw_gap: got %0d, required %0d", it, bw_gap, exp_gap(fw_delay));
                end
            end
        end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        cyc            = 0;
        rst            = 1'b0;
        run            = 1'b0;
        train          = 1'b0;
        layer_top      = '0;
        samples_total  = '0;
        fw_layer_ready = 1'b0;
        bw_layer_ready = 1'b0;
        fw_done        = 1'b0;
        bw_done        = 1'b0;
        ready_mode     = 0;
        fw_delay       = 2;
        bw_delay       = 2;
        env_top        = 0;
        fw_early       = 1'b0;
        early_sent     = 1'b0;
        bw_forbidden   = 1'b0;
        fw_cd          = 0;
        bw_cd          = 0;
        pend_fw        = 1'b0;
        pend_bw        = 1'b0;
        held_fw        = '0;
        held_bw        = '0;
        prev_bw_valid  = 1'b0;
        clear_env();

        test_reset();
        test_basic();
        test_ready_toggle();
        test_inference();
        test_early_done();
        test_top_zero();
        test_stop();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
